// File: rtl/aes_arb_pkg.sv
// Shared types for the two-requester AES core arbiter.
package aes_arb_pkg;

  localparam int AES_BLK_W = 128;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;

  typedef logic req_id_t;

  // Plaintext/key pair as captured from the granted requester
  typedef struct packed {
    logic [AES_BLK_W-1:0] state;
    logic [AES_BLK_W-1:0] key;
  } aes_req_t;

endpackage

// File: rtl/aes_arb_rr.sv
// Two-way round-robin pick: a lone requester always wins, prio breaks ties.
module aes_arb_rr
  import aes_arb_pkg::*;
(
  input  logic    valid0_i,
  input  logic    valid1_i,
  input  req_id_t prio_i,
  output logic    grant_valid_o,
  output req_id_t grant_id_o
);

  assign grant_valid_o = valid0_i | valid1_i;
  assign grant_id_o    = (valid0_i && valid1_i) ? prio_i : req_id_t'(valid1_i);

endmodule

// File: rtl/aes_core_arbiter.sv
// Shares one AES-128 core between two requesters, one block in flight.
// Optional build macro AES_ARB_TIMEOUT_EN adds a WAIT watchdog that
// answers with zero data and raises a sticky err flag.
module aes_core_arbiter
  import aes_arb_pkg::*;
  #(parameter int TIMEOUT_CYCLES = 64)
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [AES_BLK_W-1:0] req0_state,
  input  logic [AES_BLK_W-1:0] req0_key,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [AES_BLK_W-1:0] req1_state,
  input  logic [AES_BLK_W-1:0] req1_key,
  output logic                 rsp0_valid,
  input  logic                 rsp0_ready,
  output logic [AES_BLK_W-1:0] rsp0_data,
  output logic                 rsp1_valid,
  input  logic                 rsp1_ready,
  output logic [AES_BLK_W-1:0] rsp1_data,
  output logic                 core_start,
  output logic [AES_BLK_W-1:0] core_state,
  output logic [AES_BLK_W-1:0] core_key,
  input  logic                 core_done,
  input  logic [AES_BLK_W-1:0] core_out,
  output logic                 busy,
  output logic                 err
);

  arb_state_t           state_q;
  req_id_t              gnt_q, prio_q, gnt_id;
  logic                 gnt_vld;
  aes_req_t             req_q, req_sel;
  logic [AES_BLK_W-1:0] res_q;
  logic                 start_q;
  logic                 rsp_hs, idle;

`ifdef AES_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q;
  logic             err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  aes_arb_rr u_rr (
    .valid0_i      (req0_valid),
    .valid1_i      (req1_valid),
    .prio_i        (prio_q),
    .grant_valid_o (gnt_vld),
    .grant_id_o    (gnt_id)
  );

  // Mux the winning requester's block for capture
  always_comb begin
    req_sel = '{state: req0_state, key: req0_key};
    if (gnt_id) req_sel = '{state: req1_state, key: req1_key};
  end

  // Requesters are only accepted from IDLE and never while reset is held
  assign idle       = (state_q == IDLE) && !rst;
  assign req0_ready = idle && gnt_vld && (gnt_id == 1'b0);
  assign req1_ready = idle && gnt_vld && (gnt_id == 1'b1);

  assign rsp0_valid = (state_q == RESP) && (gnt_q == 1'b0);
  assign rsp1_valid = (state_q == RESP) && (gnt_q == 1'b1);
  assign rsp0_data  = rsp0_valid ? res_q : '0;
  assign rsp1_data  = rsp1_valid ? res_q : '0;
  assign rsp_hs     = gnt_q ? (rsp1_valid && rsp1_ready) : (rsp0_valid && rsp0_ready);

  assign core_start = start_q;
  assign core_state = req_q.state;
  assign core_key   = req_q.key;
  assign busy       = (state_q != IDLE);

  // Arbiter FSM: grant, launch, wait for done, hand back result
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      prio_q  <= 1'b0;
      req_q   <= '0;
      res_q   <= '0;
      start_q <= 1'b0;
`ifdef AES_ARB_TIMEOUT_EN
      tmo_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      start_q <= 1'b0;
      unique case (state_q)
        IDLE: if (gnt_vld) begin
          gnt_q   <= gnt_id;
          req_q   <= req_sel;
          start_q <= 1'b1;
          state_q <= ISSUE;
        end
        ISSUE: begin
          // A done overlapping the start pulse is deliberately dropped
          state_q <= WAIT;
`ifdef AES_ARB_TIMEOUT_EN
          tmo_q   <= '0;
`endif
        end
        WAIT: begin
          if (core_done) begin
            res_q   <= core_out;
            state_q <= RESP;
          end
`ifdef AES_ARB_TIMEOUT_EN
          else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            // Core never answered: complete the transaction with zero data
            res_q   <= '0;
            err_q   <= 1'b1;
            state_q <= RESP;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
`endif
        end
        RESP: if (rsp_hs) begin
          prio_q  <= ~gnt_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
